// File: rtl/vga_out_csc_if.sv
// vga_out_csc_if: pixel/sync bundle for the VGA output colour-space converter.
//   master drives : mode_sel, hsync, vsync, csync, de, din
//   slave drives  : dout, hsync_o, vsync_o, csync_o, de_o, mode_o
interface vga_out_csc_if #(
    parameter int DW = 8
);
    logic [1:0]      mode_sel;
    logic            hsync;
    logic            vsync;
    logic            csync;
    logic            de;
    logic [3*DW-1:0] din;
    logic [3*DW-1:0] dout;
    logic            hsync_o;
    logic            vsync_o;
    logic            csync_o;
    logic            de_o;
    logic [1:0]      mode_o;

    modport master (
        output mode_sel, hsync, vsync, csync, de, din,
        input  dout, hsync_o, vsync_o, csync_o, de_o, mode_o
    );

    modport slave (
        input  mode_sel, hsync, vsync, csync, de, din,
        output dout, hsync_o, vsync_o, csync_o, de_o, mode_o
    );
endinterface

// File: rtl/vga_out_csc.sv
// vga_out_csc: 3-stage RGB -> YPbPr (BT.601 / BT.709) converter for a VGA output.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of vga_out_csc_if
//              in : mode_sel, hsync, vsync, csync, de, din {R,G,B}
//              out: dout ({R,G,B} or {Pr,Y,Pb}), delayed syncs/de, mode_o
// Stage 1 registers the nine products, stage 2 the three rounded/offset sums,
// stage 3 the shifted, clamped and (optionally) blanked result. Every stage
// carries its own mode tag so in-flight pixels keep the mode they entered with.
module vga_out_csc #(
    parameter int DW       = 8,
    parameter bit BLANK_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    vga_out_csc_if.slave bus
);
    localparam int PW = DW + 10;   // product width
    localparam int SW = DW + 12;   // sum width, headroom for 3 products + offsets
    localparam logic signed [SW-1:0] RND  = SW'(128);
    localparam logic signed [SW-1:0] COFS = SW'((1 << (DW - 1)) * 256);
    localparam logic signed [SW-1:0] MAXV = SW'((1 << DW) - 1);
    localparam logic [DW-1:0]        HALF = DW'(1 << (DW - 1));

    // Rows: 0=Y, 1=Pb, 2=Pr. Columns: 0=R, 1=G, 2=B. Scaled by 256.
    function automatic logic signed [8:0] coef(input logic bt709, input int o, input int c);
        logic signed [8:0] k601 [3][3];
        logic signed [8:0] k709 [3][3];
        k601 = '{'{9'sd77, 9'sd150, 9'sd29},
                 '{-9'sd43, -9'sd85, 9'sd128},
                 '{9'sd128, -9'sd107, -9'sd21}};
        k709 = '{'{9'sd54, 9'sd183, 9'sd19},
                 '{-9'sd29, -9'sd99, 9'sd128},
                 '{9'sd128, -9'sd116, -9'sd12}};
        return bt709 ? k709[o][c] : k601[o][c];
    endfunction

    logic                 r_vs_d;
    logic [1:0]           r_mode;
    logic                 w_vs_rise;
    logic [1:0]           w_req_mode;

    logic signed [DW:0]   w_chan   [3];
    logic signed [PW-1:0] w_prod   [3][3];
    logic signed [PW-1:0] r_s1_prod [3][3];
    logic [3*DW-1:0]      r_s1_pix;
    logic [3:0]           r_s1_sync;      // {hsync, vsync, csync, de}
    logic [1:0]           r_s1_mode;

    logic signed [SW-1:0] w_sum    [3];
    logic signed [SW-1:0] r_s2_sum [3];
    logic [3*DW-1:0]      r_s2_pix;
    logic [3:0]           r_s2_sync;
    logic [1:0]           r_s2_mode;

    logic signed [SW-1:0] w_shift  [3];
    logic [DW-1:0]        w_clip   [3];
    logic                 w_blank;
    logic [3*DW-1:0]      w_dout;
    logic [3*DW-1:0]      r_dout;
    logic [3:0]           r_sync;
    logic [1:0]           r_mode_o;

    // Mode is only taken on the registered-vsync rising edge; 11 folds to RGB.
    assign w_vs_rise  = bus.vsync & ~r_vs_d;
    assign w_req_mode = (bus.mode_sel == 2'b11) ? 2'b00 : bus.mode_sel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_d <= 1'b0;
            r_mode <= 2'b00;
        end else begin
            r_vs_d <= bus.vsync;
            if (w_vs_rise) r_mode <= w_req_mode;
        end
    end

    always_comb begin
        for (int c = 0; c < 3; c++) w_chan[c] = $signed({1'b0, bus.din[(2-c)*DW +: DW]});
        for (int o = 0; o < 3; o++)
            for (int c = 0; c < 3; c++)
                w_prod[o][c] = PW'(coef(r_mode == 2'b10, o, c)) * PW'(w_chan[c]);
    end

    always_comb begin
        for (int o = 0; o < 3; o++)
            w_sum[o] = SW'(r_s1_prod[o][0]) + SW'(r_s1_prod[o][1]) + SW'(r_s1_prod[o][2])
                     + RND + ((o == 0) ? SW'(0) : COFS);
    end

    always_comb begin
        for (int o = 0; o < 3; o++) begin
            w_shift[o] = r_s2_sum[o] >>> 8;
            if (w_shift[o] < 0)         w_clip[o] = '0;
            else if (w_shift[o] > MAXV) w_clip[o] = MAXV[DW-1:0];
            else                        w_clip[o] = w_shift[o][DW-1:0];
        end
        w_blank = BLANK_EN && !r_s2_sync[0];
        if (r_s2_mode == 2'b00)
            w_dout = w_blank ? '0 : r_s2_pix;
        else
            w_dout = w_blank ? {HALF, {DW{1'b0}}, HALF} : {w_clip[2], w_clip[0], w_clip[1]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int o = 0; o < 3; o++) begin
                for (int c = 0; c < 3; c++) r_s1_prod[o][c] <= '0;
                r_s2_sum[o] <= '0;
            end
            r_s1_pix  <= '0;
            r_s1_sync <= '0;
            r_s1_mode <= '0;
            r_s2_pix  <= '0;
            r_s2_sync <= '0;
            r_s2_mode <= '0;
            r_dout    <= '0;
            r_sync    <= '0;
            r_mode_o  <= '0;
        end else begin
            r_s1_prod <= w_prod;
            r_s1_pix  <= bus.din;
            r_s1_sync <= {bus.hsync, bus.vsync, bus.csync, bus.de};
            r_s1_mode <= r_mode;
            r_s2_sum  <= w_sum;
            r_s2_pix  <= r_s1_pix;
            r_s2_sync <= r_s1_sync;
            r_s2_mode <= r_s1_mode;
            r_dout    <= w_dout;
            r_sync    <= r_s2_sync;
            r_mode_o  <= r_s2_mode;
        end
    end

    assign bus.dout    = r_dout;
    assign bus.hsync_o = r_sync[3];
    assign bus.vsync_o = r_sync[2];
    assign bus.csync_o = r_sync[1];
    assign bus.de_o    = r_sync[0];
    assign bus.mode_o  = r_mode_o;
endmodule

// File: tb/tb_vga_out_csc.sv
// tb_vga_out_csc: randomized + directed bench for vga_out_csc (DW=8).
// Two DUTs share the inputs: one with blanking enabled, one without.
// A behavioural model turns each sampled input into the expected output
// word; a queue delays it three cycles for the per-cycle compare.
module tb_vga_out_csc;
    localparam int DW = 8;

    typedef struct packed {
        logic [3*DW-1:0] dout;
        logic [3:0]      syn;   // {hsync, vsync, csync, de}
        logic [1:0]      mode;
    } exp_t;

    localparam exp_t ZERO = '0;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vga_out_csc_if #(.DW(DW)) bus ();
    vga_out_csc_if #(.DW(DW)) bus_nb ();

    vga_out_csc #(.DW(DW), .BLANK_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );
    vga_out_csc #(.DW(DW), .BLANK_EN(1'b0)) dut_nb (
        .clk(clk), .reset_n(reset_n), .bus(bus_nb.slave)
    );

    assign bus_nb.mode_sel = bus.mode_sel;
    assign bus_nb.hsync    = bus.hsync;
    assign bus_nb.vsync    = bus.vsync;
    assign bus_nb.csync    = bus.csync;
    assign bus_nb.de       = bus.de;
    assign bus_nb.din      = bus.din;

    int checks = 0;
    int errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [1:0] cur_mode = 2'b00;
    logic       prev_vs  = 1'b0;

    function automatic exp_t ref_px(input logic [1:0] tag, input logic [3*DW-1:0] d,
                                    input logic [3:0] syn, input bit blank_en);
        int   k [2][3][3];
        int   ch [3];
        int   v [3];
        int   acc, half, mx;
        exp_t e;
        k = '{'{'{77, 150, 29}, '{-43, -85, 128}, '{128, -107, -21}},
              '{'{54, 183, 19}, '{-29, -99, 128}, '{128, -116, -12}}};
        half  = 1 << (DW - 1);
        mx    = (1 << DW) - 1;
        e.syn  = syn;
        e.mode = tag;
        ch[0] = int'(d[3*DW-1 -: DW]);
        ch[1] = int'(d[2*DW-1 -: DW]);
        ch[2] = int'(d[DW-1:0]);
        if (blank_en && !syn[0]) begin
            e.dout = (tag == 2'b00) ? '0 : {DW'(half), DW'(0), DW'(half)};
        end else if (tag == 2'b00) begin
            e.dout = d;
        end else begin
            for (int o = 0; o < 3; o++) begin
                acc = 128 + ((o == 0) ? 0 : half * 256);
                for (int c = 0; c < 3; c++) acc += k[(tag == 2'b10) ? 1 : 0][o][c] * ch[c];
                v[o] = acc >>> 8;
                if (v[o] < 0)  v[o] = 0;
                if (v[o] > mx) v[o] = mx;
            end
            e.dout = {DW'(v[2]), DW'(v[0]), DW'(v[1])};
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic exp_t got_a();
        return '{dout: bus.dout, syn: {bus.hsync_o, bus.vsync_o, bus.csync_o, bus.de_o},
                 mode: bus.mode_o};
    endfunction

    function automatic exp_t got_b();
        return '{dout: bus_nb.dout, syn: {bus_nb.hsync_o, bus_nb.vsync_o, bus_nb.csync_o, bus_nb.de_o},
                 mode: bus_nb.mode_o};
    endfunction

    // Model: expected output for the sample taken at this edge, delayed by a queue.
    always @(posedge clk) begin
        logic [1:0] tag;
        if (!reset_n) begin
            q_a = '{ZERO, ZERO};
            q_b = '{ZERO, ZERO};
            cur_mode = 2'b00;
            prev_vs  = 1'b0;
        end else begin
            tag = cur_mode;
            q_a.push_back(ref_px(tag, bus.din, {bus.hsync, bus.vsync, bus.csync, bus.de}, 1'b1));
            q_b.push_back(ref_px(tag, bus.din, {bus.hsync, bus.vsync, bus.csync, bus.de}, 1'b0));
            if (bus.vsync && !prev_vs) cur_mode = (bus.mode_sel == 2'b11) ? 2'b00 : bus.mode_sel;
            prev_vs = bus.vsync;
            while (q_a.size() > 3) void'(q_a.pop_front());
            while (q_b.size() > 3) void'(q_b.pop_front());
        end
    end

    // Compare every cycle, away from the active edge.
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            chk("reset_out_a", got_a(), ZERO);
            chk("reset_out_b", got_b(), ZERO);
        end else if (q_a.size() == 3) begin
            chk("pipe_a", got_a(), q_a[0]);
            chk("pipe_b", got_b(), q_b[0]);
        end
    end

    task automatic drive(input logic vs, input logic de, input logic [3*DW-1:0] d,
                         input logic [1:0] ms);
        @(negedge clk);
        bus.vsync = vs; bus.de = de; bus.din = d; bus.mode_sel = ms;
        bus.hsync = 1'b0; bus.csync = 1'b0;
    endtask

    // Hold one pixel for three samples; return just after its first copy reaches dout.
    task automatic hold3(input logic de, input logic [3*DW-1:0] d, input logic [1:0] ms);
        repeat (3) drive(1'b0, de, d, ms);
        @(posedge clk); #1;
    endtask

    initial begin
        int vs_cnt;
        bus.mode_sel = 2'b00; bus.hsync = 1'b0; bus.vsync = 1'b0;
        bus.csync = 1'b0; bus.de = 1'b0; bus.din = '0;

        repeat (3) @(posedge clk); #1;
        chk("rst_dout", bus.dout, '0);
        chk("rst_mode", bus.mode_o, 2'b00);
        @(negedge clk) reset_n = 1'b1;

        // Select BT.601 on a vsync edge.
        drive(1'b0, 1'b1, 24'h000000, 2'b01);
        drive(1'b1, 1'b1, 24'h000000, 2'b01);
        hold3(1'b1, 24'hFFFFFF, 2'b01);
        chk("white601", bus.dout, 24'h80FF80);
        chk("mode01", bus.mode_o, 2'b01);
        hold3(1'b1, 24'hFF0000, 2'b01);
        chk("red601", bus.dout, 24'hFF4D55);
        hold3(1'b1, 24'h000000, 2'b01);
        chk("black601", bus.dout, 24'h800080);

        // Blanking: de low for 5 cycles.
        hold3(1'b0, 24'hFF0000, 2'b01);
        chk("blank_dout", bus.dout, 24'h800080);
        chk("blank_de_o", bus.de_o, 1'b0);
        chk("noblank_dout", bus_nb.dout, 24'hFF4D55);
        drive(1'b0, 1'b0, 24'hFF0000, 2'b01);
        drive(1'b0, 1'b0, 24'hFF0000, 2'b01);

        // Back to RGB, then request BT.709 mid-frame.
        drive(1'b1, 1'b1, 24'h111111, 2'b00);
        hold3(1'b1, 24'h123456, 2'b00);
        chk("rgb_pass", bus.dout, 24'h123456);
        hold3(1'b1, 24'h123456, 2'b10);
        chk("midframe_dout", bus.dout, 24'h123456);
        chk("midframe_mode", bus.mode_o, 2'b00);
        drive(1'b1, 1'b1, 24'h123456, 2'b10);
        drive(1'b0, 1'b1, 24'hFFFFFF, 2'b10);
        @(posedge clk);
        @(posedge clk); #1;
        chk("edge_px_dout", bus.dout, 24'h123456);
        chk("edge_px_mode", bus.mode_o, 2'b00);
        @(posedge clk); #1;
        chk("bt709_dout", bus.dout, 24'h80FF80);
        chk("bt709_mode", bus.mode_o, 2'b10);

        // Reset mid-line while in BT.709.
        @(negedge clk) reset_n = 1'b0;
        #1;
        chk("async_rst", got_a(), ZERO);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1; bus.din = 24'hABCDEF; bus.de = 1'b1; bus.vsync = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("post_rst_flush", bus.dout, '0);
        @(posedge clk); #1;
        chk("post_rst_first", bus.dout, 24'hABCDEF);
        chk("post_rst_mode", bus.mode_o, 2'b00);

        // Randomized traffic: pixels, syncs, vsync timing, mode requests, rare resets.
        vs_cnt = 5;
        for (int n = 0; n < 30000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 2999) == 0) reset_n = 1'b0;
            else reset_n = 1'b1;
            bus.din   = 24'($urandom);
            bus.de    = ($urandom_range(0, 7) != 0);
            bus.hsync = 1'($urandom_range(0, 1));
            bus.csync = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) bus.mode_sel = 2'($urandom_range(0, 3));
            vs_cnt--;
            if (vs_cnt <= 0) begin
                bus.vsync = ~bus.vsync;
                if (bus.vsync && $urandom_range(0, 1) == 1) bus.mode_sel = 2'($urandom_range(0, 3));
                vs_cnt = bus.vsync ? int'($urandom_range(1, 4)) : int'($urandom_range(2, 40));
            end
        end
        @(negedge clk) reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
